// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage register file with bypassed reads, debug port and write statistics
module wb_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemtoReg_i,
    input  logic        RegWrite_i,
    input  logic [31:0] Memdata_i,
    input  logic [31:0] ALUresult_i,
    input  logic [4:0]  RDaddr_i,
    input  logic [4:0]  RSaddr_i,
    input  logic [4:0]  RTaddr_i,
    input  logic [4:0]  DBGaddr_i,
    output logic [31:0] RSdata_o,
    output logic [31:0] RTdata_o,
    output logic [31:0] WBdata_o,
    output logic [31:0] DBGdata_o,
    output logic [31:0] wr_cnt_o,
    output logic [31:0] written_o
);

    logic [31:0] regs_q [32];
    logic [31:0] dbg_q;
    logic [31:0] wr_cnt_q;
    logic [31:0] written_q;
    logic        commit;

    assign WBdata_o = MemtoReg_i ? Memdata_i : ALUresult_i;

    // Reset and the r0 target both veto a write, which also disables bypass.
    assign commit = RegWrite_i && (RDaddr_i != 5'd0) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (commit) begin
            regs_q[RDaddr_i] <= WBdata_o;
        end
    end

    // Debug read samples pre-edge storage, so a same-cycle write shows up one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dbg_q <= 32'd0;
        end else if (DBGaddr_i == 5'd0) begin
            dbg_q <= 32'd0;
        end else begin
            dbg_q <= regs_q[DBGaddr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_q  <= 32'd0;
            written_q <= 32'd0;
        end else if (commit) begin
            if (wr_cnt_q != 32'hFFFF_FFFF) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            written_q[RDaddr_i] <= 1'b1;
        end
    end

    // During reset the register array is about to clear, so reads already present zero.
    always_comb begin
        RSdata_o = 32'd0;
        if (!rst_i && (RSaddr_i != 5'd0)) begin
            if (commit && (RDaddr_i == RSaddr_i)) begin
                RSdata_o = WBdata_o;
            end else begin
                RSdata_o = regs_q[RSaddr_i];
            end
        end
    end

    always_comb begin
        RTdata_o = 32'd0;
        if (!rst_i && (RTaddr_i != 5'd0)) begin
            if (commit && (RDaddr_i == RTaddr_i)) begin
                RTdata_o = WBdata_o;
            end else begin
                RTdata_o = regs_q[RTaddr_i];
            end
        end
    end

    assign DBGdata_o = dbg_q;
    assign wr_cnt_o  = wr_cnt_q;
    assign written_o = written_q;

endmodule
